// File: rtl/peri_uart.sv
`default_nettype none
// ============================================================================
// Module      : peri_uart (with helper peri_uart_fifo)
// Description : 8N1 UART peripheral on the core's peripheral bus: TX/RX FIFOs,
//               programmable baud divisor, sticky error flags, level interrupt.
// Revision    : 1.0  initial release
// ============================================================================

module peri_uart_fifo #(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_empty,
    output logic       o_full
);
    localparam logic [AW:0] c_depth = {1'b1, {AW{1'b0}}};

    logic [7:0]    r_mem [0:(1<<AW)-1];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_depth);
    assign o_head    = r_mem[r_rptr];
    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign w_push_ok = i_push & (~o_full | i_pop);
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_data;
    end
endmodule

module peri_uart #(
    parameter int          FIFO_AW   = 3,
    parameter logic [15:0] DIV_RESET = 16'd434,
    parameter logic [11:0] BASE      = 12'h000
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        peri_w,
    input  logic        peri_r,
    input  logic [31:0] peri_addr,
    input  logic [31:0] peri_wdat,
    output logic [31:0] peri_rdat,
    output logic        peri_ack,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        uart_int
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam logic [15:0] c_div_min = 16'd15;

    // Bus interface
    logic        w_hit, w_wr_acc, w_rd_acc;
    logic [2:0]  w_idx;
    logic [31:0] w_rdat_mux;
    logic        r_ack_q, r_rx_can_pop;
    logic [31:0] r_rdat;
    // Control / status
    logic [15:0] r_div;
    logic [1:0]  r_ie;
    logic        r_overrun, r_frame_err, r_int;
    // FIFOs
    logic        w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
    logic [7:0]  w_tx_head;
    logic        w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
    logic [7:0]  w_rx_head;
    logic        w_tx_idle;
    // TX engine
    uart_state_t r_tx_state, w_tx_state_n;
    logic [15:0] r_tx_cnt, w_tx_cnt_n, r_tx_div, w_tx_div_n;
    logic [2:0]  r_tx_bit, w_tx_bit_n;
    logic [7:0]  r_tx_sh, w_tx_sh_n;
    logic        r_uart_tx, w_tx_out_n, w_tx_last, w_tx_load;
    // RX engine
    uart_state_t r_rx_state, w_rx_state_n;
    logic [15:0] r_rx_cnt, w_rx_cnt_n, r_rx_div, w_rx_div_n, w_rx_half;
    logic [16:0] w_rx_sum;
    logic [2:0]  r_rx_bit, w_rx_bit_n;
    logic [7:0]  r_rx_sh, w_rx_sh_n;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic        w_set_ovr, w_set_ferr;
    logic        w_unused;

    assign w_unused = &{1'b0, peri_addr[31:24], peri_addr[11:5], peri_addr[1:0],
                        peri_wdat[31:16], w_rx_sum[0]};

    assign w_hit    = (peri_w | peri_r) & (peri_addr[23:12] == BASE);
    assign w_idx    = peri_addr[4:2];
    // Side effects belong to the edge that closes the ack cycle.
    assign w_wr_acc = r_ack_q & peri_w & w_hit;
    assign w_rd_acc = r_ack_q & peri_r & w_hit;

    assign w_tx_push = w_wr_acc & (w_idx == 3'd0);
    assign w_rx_pop  = w_rd_acc & (w_idx == 3'd1) & r_rx_can_pop;
    assign w_tx_idle = w_tx_empty & (r_tx_state == ST_IDLE);

    assign peri_ack  = r_ack_q;
    assign peri_rdat = r_rdat;
    assign uart_tx   = r_uart_tx;
    assign uart_int  = r_int;

    always_comb begin
        w_rdat_mux = '0;
        case (w_idx)
            3'd0: w_rdat_mux = {w_tx_full, 31'b0};
            3'd1: w_rdat_mux = {w_rx_empty, 23'b0, w_rx_head};
            3'd2: w_rdat_mux = {26'b0, r_frame_err, r_overrun, w_rx_full,
                                w_rx_empty, w_tx_full, w_tx_idle};
            3'd3: w_rdat_mux = {16'b0, r_div};
            3'd4: w_rdat_mux = {30'b0, r_ie};
            default: w_rdat_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            r_ack_q      <= 1'b0;
            r_rdat       <= '0;
            r_rx_can_pop <= 1'b0;
            r_div        <= DIV_RESET;
            r_ie         <= 2'b00;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_int        <= 1'b0;
        end else begin
            r_ack_q      <= ~r_ack_q & w_hit;
            r_rdat       <= (~r_ack_q & w_hit) ? w_rdat_mux : '0;
            // The pop decision follows the emptiness reported in the returned data.
            r_rx_can_pop <= ~r_ack_q & w_hit & ~w_rx_empty;
            if (w_wr_acc && w_idx == 3'd3)
                r_div <= (peri_wdat[15:0] < c_div_min) ? c_div_min : peri_wdat[15:0];
            if (w_wr_acc && w_idx == 3'd4)
                r_ie <= peri_wdat[1:0];
            if (w_set_ovr)
                r_overrun <= 1'b1;
            else if (w_wr_acc && w_idx == 3'd2 && peri_wdat[4])
                r_overrun <= 1'b0;
            if (w_set_ferr)
                r_frame_err <= 1'b1;
            else if (w_wr_acc && w_idx == 3'd2 && peri_wdat[5])
                r_frame_err <= 1'b0;
            r_int <= (r_ie[0] & w_tx_idle) | (r_ie[1] & ~w_rx_empty);
        end
    end

    peri_uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst(cpurst), .i_push(w_tx_push), .i_data(peri_wdat[7:0]),
        .i_pop(w_tx_pop), .o_head(w_tx_head), .o_empty(w_tx_empty), .o_full(w_tx_full)
    );

    peri_uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst(cpurst), .i_push(w_rx_push), .i_data(r_rx_sh),
        .i_pop(w_rx_pop), .o_head(w_rx_head), .o_empty(w_rx_empty), .o_full(w_rx_full)
    );

    // ---------------- TX ----------------
    assign w_tx_last = (r_tx_cnt == r_tx_div);

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt + 16'd1;
        w_tx_bit_n   = r_tx_bit;
        w_tx_sh_n    = r_tx_sh;
        w_tx_div_n   = r_tx_div;
        w_tx_pop     = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_out_n   = 1'b1;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_cnt_n = '0;
                w_tx_load  = ~w_tx_empty;
            end
            ST_START: if (w_tx_last) begin
                w_tx_cnt_n   = '0;
                w_tx_bit_n   = 3'd0;
                w_tx_state_n = ST_DATA;
            end
            ST_DATA: if (w_tx_last) begin
                w_tx_cnt_n = '0;
                w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
                if (r_tx_bit == 3'd7) w_tx_state_n = ST_STOP;
                else                  w_tx_bit_n   = r_tx_bit + 3'd1;
            end
            ST_STOP: if (w_tx_last) begin
                w_tx_cnt_n   = '0;
                w_tx_state_n = ST_IDLE;
                w_tx_load    = ~w_tx_empty;
            end
            default: w_tx_state_n = ST_IDLE;
        endcase
        // Loading a byte also latches the divisor for the whole frame.
        if (w_tx_load) begin
            w_tx_pop     = 1'b1;
            w_tx_sh_n    = w_tx_head;
            w_tx_div_n   = r_div;
            w_tx_state_n = ST_START;
        end
        case (w_tx_state_n)
            ST_START: w_tx_out_n = 1'b0;
            ST_DATA:  w_tx_out_n = w_tx_sh_n[0];
            default:  w_tx_out_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
            r_tx_div   <= DIV_RESET;
            r_uart_tx  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_sh    <= w_tx_sh_n;
            r_tx_div   <= w_tx_div_n;
            r_uart_tx  <= w_tx_out_n;
        end
    end

    // ---------------- RX ----------------
    assign w_rx_sum  = {1'b0, r_rx_div} + 17'd1;
    assign w_rx_half = w_rx_sum[16:1];

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt + 16'd1;
        w_rx_bit_n   = r_rx_bit;
        w_rx_sh_n    = r_rx_sh;
        w_rx_div_n   = r_rx_div;
        w_rx_push    = 1'b0;
        w_set_ovr    = 1'b0;
        w_set_ferr   = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                w_rx_cnt_n = '0;
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_cnt_n   = 16'd1;
                    w_rx_div_n   = r_div;
                    w_rx_state_n = ST_START;
                end
            end
            ST_START: if (r_rx_cnt == w_rx_half) begin
                w_rx_cnt_n   = '0;
                w_rx_bit_n   = 3'd0;
                // A high line at mid start bit is treated as a glitch.
                w_rx_state_n = r_rx_s2 ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (r_rx_cnt == r_rx_div) begin
                w_rx_cnt_n = '0;
                w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
                if (r_rx_bit == 3'd7) w_rx_state_n = ST_STOP;
                else                  w_rx_bit_n   = r_rx_bit + 3'd1;
            end
            ST_STOP: if (r_rx_cnt == r_rx_div) begin
                w_rx_cnt_n   = '0;
                w_rx_state_n = ST_IDLE;
                if (!r_rx_s2)                  w_set_ferr = 1'b1;
                else if (w_rx_full && !w_rx_pop) w_set_ovr = 1'b1;
                else                           w_rx_push  = 1'b1;
            end
            default: w_rx_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
            r_rx_div   <= DIV_RESET;
        end else begin
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_sh    <= w_rx_sh_n;
            r_rx_div   <= w_rx_div_n;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_peri_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_peri_uart
// Description : Directed self-checking bench for peri_uart (bus, TX, RX, IRQ).
// Revision    : 1.0  initial release
// ============================================================================
module tb_peri_uart;
    logic        clk = 1'b0;
    logic        cpurst = 1'b1;
    logic        peri_w = 1'b0;
    logic        peri_r = 1'b0;
    logic [31:0] peri_addr = '0;
    logic [31:0] peri_wdat = '0;
    logic [31:0] peri_rdat;
    logic        peri_ack;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        uart_int;

    localparam logic [31:0] A_TX = 32'h00, A_RX = 32'h04, A_ST = 32'h08;
    localparam logic [31:0] A_DIV = 32'h0C, A_IE = 32'h10, A_UNM = 32'h14;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] mon_q [$];
    logic [7:0] mon_b;

    always #5 clk = ~clk;

    peri_uart #(.FIFO_AW(3), .DIV_RESET(16'd434), .BASE(12'h000)) dut (
        .clk(clk), .cpurst(cpurst), .peri_w(peri_w), .peri_r(peri_r),
        .peri_addr(peri_addr), .peri_wdat(peri_wdat), .peri_rdat(peri_rdat),
        .peri_ack(peri_ack), .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_int(uart_int)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One bus access; the request is held through the cycle that closes the ack.
    task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                       output logic [31:0] rdat);
        int lat;
        peri_addr = addr;
        peri_wdat = wdat;
        peri_w    = wr;
        peri_r    = ~wr;
        lat       = 0;
        while (lat < 20) begin
            tick(1);
            lat++;
            if (peri_ack) break;
        end
        check($sformatf("ack_latency@%0h", addr), lat, 1);
        rdat = peri_rdat;
        tick(1);
        peri_w = 1'b0;
        peri_r = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdat);
        logic [31:0] dummy;
        bus(1'b1, addr, wdat, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] rdat);
        bus(1'b0, addr, 32'h0, rdat);
    endtask

    // Drives one 8N1 frame at 16 clocks per bit.
    task automatic send_rx(input logic [7:0] b, input logic stopb);
        uart_rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(16);
        end
        uart_rx = stopb;
        tick(16);
        uart_rx = 1'b1;
        tick(4);
    endtask

    // TX line decoder, assumes 16 clocks per bit.
    initial begin
        forever begin
            tick(1);
            if (uart_tx === 1'b0) begin
                tick(8);
                for (int i = 0; i < 8; i++) begin
                    tick(16);
                    mon_b[i] = uart_tx;
                end
                mon_q.push_back(mon_b);
                tick(16);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] acc;
        logic [9:0]  exp_bits;
        logic [6:1]  pat;
        logic        ok;
        int          w;

        tick(3);
        check("rst_ack", peri_ack, 0);
        check("rst_rdat", peri_rdat, 0);
        check("rst_tx", uart_tx, 1);
        check("rst_int", uart_int, 0);
        cpurst = 1'b0;
        tick(2);

        rd(A_ST, d);   check("status_reset", d, 32'h5);
        rd(A_DIV, d);  check("div_reset", d, 32'd434);
        wr(A_DIV, 32'd3);
        rd(A_DIV, d);  check("div_clamp", d, 32'd15);
        rd(A_UNM, d);  check("unmapped_rd", d, 0);
        wr(A_UNM, 32'hFFFF_FFFF);
        rd(A_IE, d);   check("ie_untouched", d, 0);

        // Access outside the window must never be acknowledged
        peri_r = 1'b1;
        peri_addr = 32'h0000_1008;
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            acc = acc | {31'b0, peri_ack} | peri_rdat;
        end
        peri_r = 1'b0;
        check("miss_no_ack", acc, 0);
        tick(2);

        // Single byte 0xA5, bit-exact waveform
        wr(A_TX, 32'hA5);
        w = 0;
        while (uart_tx !== 1'b0 && w < 10) begin
            tick(1);
            w++;
        end
        check("tx_start_seen", uart_tx, 0);
        exp_bits = {1'b1, 8'hA5, 1'b0};
        for (int p = 0; p < 10; p++) begin
            ok = 1'b1;
            for (int c = 0; c < 16; c++) begin
                if (uart_tx !== exp_bits[p]) ok = 1'b0;
                tick(1);
            end
            check($sformatf("tx_period%0d", p), ok, 1);
        end
        rd(A_ST, d);   check("status_tx_done", d, 32'h5);
        check("mon_a5_cnt", mon_q.size(), 1);
        check("mon_a5_byte", mon_q[0], 32'hA5);

        // Ten writes: one goes straight to the shifter, eight fill the FIFO, the last is dropped
        mon_q.delete();
        for (int i = 0; i < 10; i++) wr(A_TX, 32'h10 + i);
        rd(A_TX, d);   check("txdata_full", d, 32'h8000_0000);
        rd(A_ST, d);   check("status_tx_busy_full", d, 32'h6);
        w = 0;
        while (mon_q.size() < 9 && w < 3000) begin
            tick(1);
            w++;
        end
        tick(200);
        check("tx_frame_count", mon_q.size(), 9);
        ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (mon_q[i] !== 8'(8'h10 + i)) ok = 1'b0;
        end
        check("tx_frame_bytes", ok, 1);

        // RX single frame
        send_rx(8'h3C, 1'b1);
        rd(A_RX, d);   check("rx_3c", d, 32'h3C);
        rd(A_RX, d);   check("rx_empty_bit", d[31], 1);

        // RX overrun and frame error
        for (int i = 0; i < 8; i++) send_rx(8'(8'h40 + i), 1'b1);
        rd(A_ST, d);   check("status_rx_full", d, 32'h09);
        send_rx(8'hEE, 1'b1);
        rd(A_ST, d);   check("status_overrun", d, 32'h19);
        wr(A_ST, 32'h10);
        rd(A_ST, d);   check("overrun_clear", d, 32'h09);
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(A_RX, d);
            if (d !== {24'b0, 8'(8'h40 + i)}) ok = 1'b0;
        end
        check("rx_drain_bytes", ok, 1);
        rd(A_RX, d);   check("rx_drained_empty", d[31], 1);
        send_rx(8'h77, 1'b0);
        rd(A_ST, d);   check("status_frame_err", d, 32'h25);
        rd(A_RX, d);   check("ferr_no_push", d[31], 1);
        wr(A_ST, 32'h20);
        rd(A_ST, d);   check("frame_err_clear", d, 32'h05);

        // Interrupts
        wr(A_IE, 32'h2);
        rd(A_IE, d);   check("ie_rd", d, 32'h2);
        check("int_low_empty", uart_int, 0);
        send_rx(8'h5A, 1'b1);
        check("int_rx_high", uart_int, 1);
        rd(A_RX, d);   check("rx_5a", d, 32'h5A);
        check("int_held_at_pop", uart_int, 1);
        tick(1);
        check("int_fall_after_pop", uart_int, 0);
        wr(A_IE, 32'h1);
        tick(1);
        check("int_tx_idle", uart_int, 1);
        wr(A_IE, 32'h0);
        tick(1);
        check("int_disabled", uart_int, 0);

        // Held read request: ack every second cycle
        peri_addr = A_TX;
        peri_r = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            pat[i] = peri_ack;
            tick(1);
        end
        peri_r = 1'b0;
        check("ack_pattern", {26'b0, pat}, 32'b101010);
        tick(2);

        // Reset in the middle of a frame
        wr(A_TX, 32'h00);
        tick(20);
        check("tx_low_midframe", uart_tx, 0);
        cpurst = 1'b1;
        tick(1);
        check("reset_abort_tx", uart_tx, 1);
        cpurst = 1'b0;
        tick(2);
        rd(A_ST, d);   check("status_after_reset", d, 32'h5);
        rd(A_DIV, d);  check("div_after_reset", d, 32'd434);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
